// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word type, cache FSM states and memory address builder.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {IDLE, WB, FILL, FLUSH} dcache_assoc_state_t;
    function automatic word_t mk_addr(input word_t tag, input word_t idx, input word_t off, input int blk_w, input int idx_w);
        return (tag << (2 + blk_w + idx_w)) | (idx << (2 + blk_w)) | (off << 2);
    endfunction
endpackage

// File: rtl/dcache_lru.sv
// dcache_lru: per-set true-LRU age permutation; victim is the way aged WAYS-1.
module dcache_lru
    import cpu_types_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int AGE_W = $clog2(WAYS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] i_set,
    input  logic [AGE_W-1:0] i_way,
    input  logic             i_touch,
    output logic [AGE_W-1:0] o_victim
);
    logic [AGE_W-1:0] r_age [SETS][WAYS];
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= AGE_W'(w);
        end else if (i_touch) begin
            for (int w = 0; w < WAYS; w++)
                if (AGE_W'(w) == i_way)
                    r_age[i_set][w] <= '0;
                else if (r_age[i_set][w] < r_age[i_set][i_way])
                    r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
        end
    end
    always_comb begin
        o_victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_age[i_set][w] == AGE_W'(WAYS - 1))
                o_victim = AGE_W'(w);
    end
endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back, write-allocate data cache
// with true-LRU replacement, halt-triggered flush and hit/miss counters.
module dcache_assoc
    import cpu_types_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SETS      = 8,
    parameter int BLK_WORDS = 2
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemaddr,
    input  word_t dmemstore,
    input  logic  halt,
    output logic  dhit,
    output word_t dmemload,
    output logic  flushed,
    output word_t hit_count,
    output word_t miss_count,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    input  word_t dload,
    input  logic  dwait
);
    localparam int BLK_W  = $clog2(BLK_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int AGE_W  = $clog2(WAYS);
    localparam int TAG_W  = 30 - BLK_W - IDX_W;
    localparam int OFF_W  = (BLK_W > 0) ? BLK_W : 1;
    localparam int LINE_W = IDX_W + AGE_W;

    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [TAG_W-1:0]      tag;
        word_t [BLK_WORDS-1:0] data;
    } line_t;

    line_t               r_lines [SETS][WAYS];
    dcache_assoc_state_t r_state;
    logic [OFF_W-1:0]    r_word;
    logic [LINE_W-1:0]   r_line;
    logic                r_missed;
    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx, w_fset;
    logic [TAG_W-1:0]    w_tag;
    logic [AGE_W-1:0]    w_hit_way, w_victim, w_lru_victim, w_fway;
    logic                w_hit, w_req, w_last, w_fdirty, w_line_done;
    line_t               w_vline, w_fline;

    assign w_off       = (BLK_W > 0) ? OFF_W'(dmemaddr >> 2) : '0;
    assign w_idx       = IDX_W'(dmemaddr >> (2 + BLK_W));
    assign w_tag       = TAG_W'(dmemaddr >> (2 + BLK_W + IDX_W));
    assign w_fset      = r_line[LINE_W-1:AGE_W];
    assign w_fway      = r_line[AGE_W-1:0];
    assign w_vline     = r_lines[w_idx][w_victim];
    assign w_fline     = r_lines[w_fset][w_fway];
    assign w_req       = dmemREN | dmemWEN;
    assign w_last      = r_word == OFF_W'(BLK_WORDS - 1);
    assign w_fdirty    = w_fline.valid & w_fline.dirty;
    assign w_line_done = !w_fdirty || (!dwait && w_last);

    // Invalid ways are filled lowest-first before LRU eviction is considered.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_victim  = w_lru_victim;
        for (int w = 0; w < WAYS; w++)
            if (r_lines[w_idx][w].valid && r_lines[w_idx][w].tag == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = AGE_W'(w);
            end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_lines[w_idx][w].valid)
                w_victim = AGE_W'(w);
    end

    assign dhit     = (r_state == IDLE) && !halt && w_req && w_hit;
    assign dmemload = r_lines[w_idx][w_hit_way].data[w_off];
    assign dREN     = r_state == FILL;
    assign dWEN     = (r_state == WB) || (r_state == FLUSH && w_fdirty);
    assign dstore   = (r_state == WB) ? w_vline.data[r_word] : w_fline.data[r_word];
    assign daddr    = (r_state == WB)    ? mk_addr(word_t'(w_vline.tag), word_t'(w_idx), word_t'(r_word), BLK_W, IDX_W) :
                      (r_state == FILL)  ? mk_addr(word_t'(w_tag), word_t'(w_idx), word_t'(r_word), BLK_W, IDX_W) :
                      (r_state == FLUSH) ? mk_addr(word_t'(w_fline.tag), word_t'(w_fset), word_t'(r_word), BLK_W, IDX_W) : '0;

    dcache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .CLK(CLK), .RST(RST), .i_set(w_idx), .i_way(w_hit_way), .i_touch(dhit), .o_victim(w_lru_victim)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_line     <= '0;
            r_missed   <= 1'b0;
            flushed    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    r_lines[s][w].valid <= 1'b0;
                    r_lines[s][w].dirty <= 1'b0;
                end
        end else begin
            case (r_state)
                IDLE: begin
                    r_word <= '0;
                    r_line <= '0;
                    if (halt) begin
                        if (!flushed) r_state <= FLUSH;
                    end else if (w_req && w_hit) begin
                        if (dmemWEN) begin
                            r_lines[w_idx][w_hit_way].data[w_off] <= dmemstore;
                            r_lines[w_idx][w_hit_way].dirty       <= 1'b1;
                        end
                        if (!r_missed && hit_count != '1) hit_count <= hit_count + 1'b1;
                        r_missed <= 1'b0;
                    end else if (w_req) begin
                        r_missed <= 1'b1;
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        r_state <= (w_vline.valid && w_vline.dirty) ? WB : FILL;
                    end
                end
                WB: if (!dwait) begin
                    r_word  <= w_last ? '0 : r_word + 1'b1;
                    r_state <= w_last ? FILL : WB;
                end
                FILL: if (!dwait) begin
                    r_lines[w_idx][w_victim].data[r_word] <= dload;
                    r_word <= w_last ? '0 : r_word + 1'b1;
                    if (w_last) begin
                        r_lines[w_idx][w_victim].valid <= 1'b1;
                        r_lines[w_idx][w_victim].dirty <= 1'b0;
                        r_lines[w_idx][w_victim].tag   <= w_tag;
                        r_state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (w_line_done) begin
                        r_word <= '0;
                        r_line <= r_line + 1'b1;
                        r_lines[w_fset][w_fway].dirty <= 1'b0;
                        if (r_line == '1) begin
                            flushed <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else if (!dwait) r_word <= r_word + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed and random accesses against a recency-list cache
// model and an architectural memory image, with a waiting memory responder.
module tb_dcache_assoc;
    import cpu_types_pkg::*;
    localparam int WAYS = 4, SETS = 8, N = 4;
    localparam int OFFB = 2 + $clog2(N), IB = OFFB + $clog2(SETS);

    logic  CLK = 1'b0, RST = 1'b1, dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0, dwait = 1'b0;
    word_t dmemaddr = '0, dmemstore = '0, dload = '0;
    logic  dhit, flushed, dREN, dWEN;
    word_t dmemload, hit_count, miss_count, daddr, dstore;

    dcache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLK_WORDS(N)) dut (
        .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .hit_count(hit_count), .miss_count(miss_count), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    int    checks = 0, fails = 0;
    word_t mem[word_t], shadow[word_t];
    word_t wr_a[$], wr_d[$], rd_a[$];
    int    g_wait = 0, wcnt = 0;
    bit    stall = 0, p_wait = 0;
    word_t p_addr = '0;
    bit    m_valid[SETS][WAYS], m_dirty[SETS][WAYS];
    int    m_tag[SETS][WAYS];
    int    m_rec[SETS][$];
    int    exp_hits = 0, exp_miss = 0;

    function automatic word_t init_val(input word_t a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    function automatic word_t mrd(input word_t a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic word_t srd(input word_t a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input word_t got, input word_t exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at a negedge: answer memory, sample, log completions.
    task automatic cyc_mem(output bit h, output word_t rd);
        #1;
        dwait = stall || ((dREN || dWEN) && wcnt < g_wait);
        if ((dREN || dWEN) && !stall) wcnt = dwait ? wcnt + 1 : 0;
        dload = mrd(daddr);
        #1;
        if (p_wait) chk("addr_stable", daddr, p_addr);
        chk("ren_wen_excl", word_t'(dREN & dWEN), 0);
        p_wait = (dREN || dWEN) && dwait;
        p_addr = daddr;
        h = dhit;
        rd = dmemload;
        if (dWEN && !dwait) begin
            mem[daddr] = dstore;
            wr_a.push_back(daddr);
            wr_d.push_back(dstore);
        end
        if (dREN && !dwait) rd_a.push_back(daddr);
        @(negedge CLK);
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rec[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_rec[s].push_back(w);
            end
        end
    endtask

    // Recency list per set, most recently used at the front.
    task automatic model_access(input bit wr, input word_t a, output int kind, output word_t vb);
        int s, t, h, v, pos;
        s = int'((a >> OFFB) % SETS);
        t = int'(a >> IB);
        h = -1;
        kind = 0;
        vb = '0;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) h = w;
        if (h < 0) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) v = m_rec[s][m_rec[s].size() - 1];
            kind = (m_valid[s][v] && m_dirty[s][v]) ? 2 : 1;
            vb = (word_t'(m_tag[s][v]) << IB) | (word_t'(s) << OFFB);
            m_valid[s][v] = 1;
            m_dirty[s][v] = 0;
            m_tag[s][v] = t;
            h = v;
        end
        pos = 0;
        for (int i = 0; i < m_rec[s].size(); i++) if (m_rec[s][i] == h) pos = i;
        m_rec[s].delete(pos);
        m_rec[s].push_front(h);
        if (wr) m_dirty[s][h] = 1;
    endtask

    task automatic access(input bit wr, input bit both, input word_t a, input word_t d, output int cyc);
        int kind;
        word_t vb, rd, base;
        bit h;
        model_access(wr, a, kind, vb);
        if (kind == 0) exp_hits++; else exp_miss++;
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        wcnt = 0;
        dmemaddr = a; dmemstore = d; dmemWEN = wr; dmemREN = !wr || both;
        cyc = 0; h = 0; rd = '0;
        while (cyc <= 400) begin
            cyc_mem(h, rd);
            if (h) break;
            cyc++;
        end
        dmemREN = 0; dmemWEN = 0;
        chk("dhit_seen", word_t'(h), 1);
        chk("latency", cyc, (kind == 0) ? 0 : 1 + kind * N * (g_wait + 1));
        if (!wr) chk("rdata", rd, srd(a));
        chk("wb_count", wr_a.size(), (kind == 2) ? N : 0);
        for (int k = 0; k < wr_a.size() && k < N; k++) begin
            chk("wb_addr", wr_a[k], vb + word_t'(4 * k));
            chk("wb_data", wr_d[k], srd(vb + word_t'(4 * k)));
        end
        base = a & ~word_t'(N * 4 - 1);
        chk("fill_count", rd_a.size(), (kind != 0) ? N : 0);
        for (int k = 0; k < rd_a.size() && k < N; k++) chk("fill_addr", rd_a[k], base + word_t'(4 * k));
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_miss);
        if (wr) shadow[a] = d;
    endtask

    task automatic do_reset();
        RST = 1; halt = 0; dmemREN = 0; dmemWEN = 0; dwait = 0; stall = 0;
        repeat (2) @(negedge CLK);
        RST = 0; p_wait = 0; wcnt = 0;
        model_reset();
        shadow = mem;
        exp_hits = 0; exp_miss = 0;
    endtask

    task automatic run_flush(input int exp_cyc, input int exp_wr);
        int cyc;
        bit h;
        word_t rd;
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        g_wait = 0; halt = 1; dmemREN = 1; cyc = 0;
        while (cyc < 2000) begin
            cyc_mem(h, rd);
            chk("flush_dhit", word_t'(h), 0);
            cyc++;
            if (flushed) break;
        end
        chk("flushed", word_t'(flushed), 1);
        chk("flush_cycles", cyc, exp_cyc);
        chk("flush_writes", wr_a.size(), exp_wr);
        halt = 0; dmemREN = 0;
    endtask

    initial begin
        int cyc, d;
        bit wr;
        word_t a;
        mem[32'h40] = 32'h11;
        mem[32'h44] = 32'h22;
        do_reset();
        chk("rst_dhit", word_t'(dhit), 0);
        chk("rst_dren", word_t'(dREN), 0);
        chk("rst_dwen", word_t'(dWEN), 0);
        chk("rst_flushed", word_t'(flushed), 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);

        access(0, 0, 32'h40, 0, cyc);
        access(0, 0, 32'h44, 0, cyc);
        chk("second_read_hit", cyc, 0);

        for (int k = 0; k < 5; k++) access(1, 0, 32'h1000 + word_t'(k) * 32'h100, 32'hDEAD, cyc);
        chk("evict_mem_1000", mrd(32'h1000), 32'hDEAD);

        access(0, 0, 32'h2010, 0, cyc);
        access(0, 0, 32'h2110, 0, cyc);
        access(0, 0, 32'h2210, 0, cyc);
        access(0, 0, 32'h2310, 0, cyc);
        access(0, 0, 32'h2010, 0, cyc);
        access(0, 0, 32'h2410, 0, cyc);
        access(0, 0, 32'h2110, 0, cyc);
        chk("lru_second_touched_evicted", word_t'(cyc > 0), 1);

        g_wait = 5;
        access(0, 0, 32'h5030, 0, cyc);
        chk("slow_fill_cycles", cyc, 1 + 6 * N);

        for (int i = 0; i < 200; i++) begin
            g_wait = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            a = (word_t'($urandom_range(0, 7)) << IB) | (word_t'($urandom_range(0, 3)) << OFFB) | (word_t'($urandom_range(0, N - 1)) << 2);
            access(wr, 1'($urandom_range(0, 1)), a, $urandom, cyc);
        end

        d = 0;
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_dirty[s][w]) d++;
        dmemaddr = 32'h40;
        run_flush(1 + SETS * WAYS - d + d * N, d * N);
        foreach (shadow[k]) chk("mem_image", mrd(k), shadow[k]);

        do_reset();
        chk("rst2_flushed", word_t'(flushed), 0);
        run_flush(SETS * WAYS + 1, 0);

        do_reset();
        g_wait = 0;
        for (int k = 0; k < 4; k++) access(1, 0, 32'h4020 + word_t'(k) * 32'h100, 32'hA0 + word_t'(k), cyc);
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        wcnt = 0; dmemaddr = 32'h4420; dmemstore = 32'hBEEF; dmemWEN = 1;
        cyc_mem(wr, a);
        cyc_mem(wr, a);
        stall = 1; RST = 1;
        cyc_mem(wr, a);
        chk("rst_wb1_addr", p_addr, 32'h4024);
        chk("rst_wb_done_before", wr_a.size(), 1);
        #2;
        chk("rst_abort_dren", word_t'(dREN), 0);
        chk("rst_abort_dwen", word_t'(dWEN), 0);
        do_reset();
        chk("rst_abort_no_more_writes", wr_a.size(), 1);
        access(0, 0, 32'h4420, 0, cyc);
        chk("rst_reread_misses", word_t'(cyc > 0), 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised N-way set-associative write-back, write-allocate data cache: the successor to the fixed 2-way / 8-set / 2-word-block dcache. It sits between the datapath memory port and the memory arbiter. It adds configurable ways, sets and block size, true-LRU replacement, invalid-way-first allocation and hit/miss performance counters. It keeps the halt-triggered flush of all dirty lines.

## Interface
- WAYS, 2, associativity; power of two, 2..8
- SETS, 8, sets; power of two, 2..64
- BLK_WORDS, 2, 32-bit words per block; power of two, 1..8
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset; synchronous and active-high
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request
- dmemaddr  in  32  datapath byte address; bits [1:0] ignored
- dmemstore  in  32  datapath write data
- halt  in  1  flush request; level, held until flushed
- dhit  out  1  request complete this cycle
- dmemload  out  32  read data; valid when dhit && dmemREN
- flushed  out  1  flush finished; sticky until RST
- hit_count  out  32  saturating count of first-attempt hits
- miss_count  out  32  saturating count of misses
- dREN  out  1  memory read
- dWEN  out  1  memory write
- daddr  out  32  memory word address
- dstore  out  32  memory write data
- dload  in  32  memory read data
- dwait  in  1  memory busy; a transaction completes on a cycle with dwait low

## Operation
- Address split, LSB first: byte[2], blkoff[log2 BLK_WORDS], idx[log2 SETS], tag = remaining bits.
- Line contents: valid, dirty, tag, BLK_WORDS data words.
- Each set has WAYS age fields, each log2(WAYS) wide, kept as a permutation.
- On any access, the touched way gets age 0. Every way whose age was below the touched way's old age increments.
- Victim selection: the lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- Request priority: halt > dmemWEN > dmemREN. A request with both dmemWEN and dmemREN set is treated as a write.
- FSM states:
  - IDLE
    - Read hit: dhit=1 and dmemload driven combinationally; update LRU.
    - Write hit: write the word, set dirty, dhit=1, update LRU.
    - Miss with a dirty victim: go to WB.
    - Miss with a clean victim: go to FILL.
    - halt && !flushed: go to FLUSH.
  - WB
    - Write victim words 0..BLK_WORDS-1 to {victim tag, idx, word, 2'b00}, one word per transaction.
    - After the last word, go to FILL.
  - FILL
    - Read words 0..BLK_WORDS-1 of the requested block, in order, into the victim line.
    - After the last word: valid=1, dirty=0, tag written; return to IDLE.
    - The retried request then hits, so a write miss completes as a write hit.
  - FLUSH
    - Scan the lines in (set, way) order, with way as the inner loop.
    - Clean or invalid lines cost 1 cycle each.
    - Dirty lines are written back word by word, then dirty is cleared.
    - After the last line, set flushed=1 and go to IDLE.
- A single word counter and a single line counter are shared by WB, FILL and FLUSH; both are zeroed on each state entry.
- hit_count increments on a hit in IDLE that was not preceded by a miss for the same request.
- miss_count increments on the IDLE->WB or IDLE->FILL transition.
- Both counters saturate at 32'hFFFFFFFF.

## Timing
- Hit latency: 0 cycles (dhit in the request cycle).
- Clean-miss latency with dwait never asserted: BLK_WORDS cycles in FILL, plus a 1-cycle hit in IDLE.
- Dirty-miss latency adds BLK_WORDS cycles of WB.
- dREN and dWEN are never high together.
- daddr and dstore stay stable while dwait is high.
- The word counter advances only on cycles with dwait low.
- Flush duration with no dirty lines: SETS*WAYS + 1 cycles to flushed.
- dhit is low in all non-IDLE states and whenever halt is high.
- Reset values:
  - state IDLE; all valid, dirty and age fields 0.
  - Ages are then initialised to way index on the first RST cycle; either the RST cycle or a dedicated init is acceptable, provided ages form a permutation before the first access.
  - All counters 0; flushed=0; dREN=dWEN=0; dhit=0.
- RST mid-miss or mid-flush aborts immediately with no memory write completed afterwards. Partially filled lines are lost (valid=0).
- Requests are not latched. The datapath holds dmemaddr, dmemREN, dmemWEN and dmemstore stable until dhit. The cache uses the live address throughout WB and FILL.

## Structure
- cpu_types_pkg carries:
  - word_t
  - a dcache_assoc_state_t enum (IDLE, WB, FILL, FLUSH)
  - a parametrised-width line struct, built in the module through localparams derived from the parameters
- Localparams: BLK_W, IDX_W, AGE_W, TAG_W = 30 - BLK_W - IDX_W.
- One sub-module, dcache_lru, holds the per-set age array and provides:
  - inputs: set index, touched way, access strobe
  - output: victim way, combinational

## Test plan
- WAYS=2, SETS=8, BLK_WORDS=2: read 0x40 (memory holds 0x11 at 0x40, 0x22 at 0x44), then read 0x44 -> the first read misses, with memory reads at 0x40 and 0x44; the second read hits with dmemload=0x22, hit_count=1, miss_count=1.
- WAYS=4, BLK_WORDS=4: write 0xDEAD to 0x1000, 0x1100, 0x1200, 0x1300, 0x1400 (all mapping to set 0) -> the fifth write evicts 0x1000's line; memory writes occur at 0x1000..0x100C with 0xDEAD at 0x1000.
- WAYS=4: touch ways 0,1,2,3, re-read way 0, then miss -> the victim is the way holding the second-touched line.
- dwait held high for 5 cycles per transaction during FILL -> daddr stays stable; fill completes after 5*BLK_WORDS + BLK_WORDS cycles.
- Dirty lines in set 0 way 1 and set 7 way 0, then halt -> exactly 2*BLK_WORDS memory writes; flushed=1 after the scan; dhit stays 0.
- RST asserted during WB word 1 -> next cycle dREN=dWEN=0, state IDLE, a re-read of the same address misses.
